add_multi_seq: RTL and testbench

Sequential multi-operand unsigned adder. It accepts N operands of W bits, one per accepted handshake, and accumulates them through an internal ripple-carry chain built from `fa` instances. It then presents the OW-bit sum and an overflow flag on a valid/ready output port. It is the parametrised successor to the fixed 3-operand, 4-bit combinational adder, and is used wherever a stream of operands must be summed without instantiating N-1 parallel adders.

---
 rtl/add_multi_seq.sv | 114 +++++++++++
 tb/tb_add_multi_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/add_multi_seq.sv
// add_multi_seq: sequential N-operand unsigned adder built on a ripple chain of fa cells.
// Define ADD_MULTI_SEQ_SAT_EN to saturate the sum at all-ones instead of wrapping.

module fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module add_multi_seq #(
   parameter int W  = 4,
   parameter int N  = 3,
   parameter int OW = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] out_sum,
   output logic          out_ovf
);
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {ACCUM, DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [OW-1:0] acc_q, acc_d;
   logic          ovf_q, ovf_d;

   logic [OW-1:0] opnd;
   logic [OW-1:0] chain_sum;
   logic [OW:0]   carry;

   always_comb begin
      opnd         = '0;
      opnd[W-1:0]  = in_data;
   end

   assign carry[0] = 1'b0;

   for (genvar i = 0; i < OW; i++) begin : g_chain
      fa u_fa (
         .a    (acc_q[i]),
         .b    (opnd[i]),
         .cin  (carry[i]),
         .s    (chain_sum[i]),
         .cout (carry[i+1])
      );
   end

   // NOTE: every output of this block is given a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         ACCUM: begin
            if (in_valid) begin
               acc_d = chain_sum;
               if (carry[OW]) ovf_d = 1'b1;
`ifdef ADD_MULTI_SEQ_SAT_EN
               // Once the true sum has overflowed, pin the accumulator at full scale.
               if (ovf_q || carry[OW]) acc_d = '1;
`endif
               if (count_q == CW'(N - 1)) begin
                  count_d = '0;
                  state_d = DONE;
               end else begin
                  count_d = count_q + CW'(1);
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               acc_d   = '0;
               ovf_d   = 1'b0;
               state_d = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ACCUM;
         count_q <= '0;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == DONE);
   assign out_sum   = acc_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_add_multi_seq.sv
// Bench for add_multi_seq: three instances (default, OW=4, N=1) checked each cycle against a
// sum-of-operands model, plus literal expectations. Honours ADD_MULTI_SEQ_SAT_EN.

module tb_add_multi_seq;

   localparam int NP  [3] = '{3, 3, 1};
   localparam int OWP [3] = '{6, 4, 6};

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid  [3];
   logic [3:0] in_data   [3];
   logic       out_ready [3];
   logic       d_ir      [3];
   logic       d_ov      [3];
   logic       d_of      [3];
   logic [5:0] sum0;
   logic [3:0] sum1;
   logic [5:0] sum2;
   longint     dsum      [3];

   int n_pass  = 0;
   int n_total = 0;

   // model: running true sum and operand count per instance
   bit     m_pend      [3];
   int     m_cnt       [3];
   longint m_tot       [3];
   bit     m_after_rst [3];

   always #5 clk = ~clk;

   add_multi_seq #(.W(4), .N(3), .OW(6)) u_dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(d_ir[0]),
      .in_data(in_data[0]), .out_valid(d_ov[0]), .out_ready(out_ready[0]),
      .out_sum(sum0), .out_ovf(d_of[0]));

   add_multi_seq #(.W(4), .N(3), .OW(4)) u_dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(d_ir[1]),
      .in_data(in_data[1]), .out_valid(d_ov[1]), .out_ready(out_ready[1]),
      .out_sum(sum1), .out_ovf(d_of[1]));

   add_multi_seq #(.W(4), .N(1), .OW(6)) u_dut2 (
      .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(d_ir[2]),
      .in_data(in_data[2]), .out_valid(d_ov[2]), .out_ready(out_ready[2]),
      .out_sum(sum2), .out_ovf(d_of[2]));

   always_comb begin
      dsum[0] = longint'(sum0);
      dsum[1] = longint'(sum1);
      dsum[2] = longint'(sum2);
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic longint max_of(input int i);
      return (longint'(1) << OWP[i]) - 1;
   endfunction

   function automatic longint exp_sum(input int i);
`ifdef ADD_MULTI_SEQ_SAT_EN
      return (m_tot[i] > max_of(i)) ? max_of(i) : m_tot[i];
`else
      return m_tot[i] & max_of(i);
`endif
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         m_after_rst[i] <= reset;
         if (reset) begin
            m_pend[i] <= 1'b0;
            m_cnt[i]  <= 0;
            m_tot[i]  <= 0;
         end else if (!m_pend[i] && in_valid[i]) begin
            m_tot[i] <= m_tot[i] + longint'(in_data[i]);
            if (m_cnt[i] + 1 == NP[i]) begin
               m_pend[i] <= 1'b1;
               m_cnt[i]  <= 0;
            end else begin
               m_cnt[i] <= m_cnt[i] + 1;
            end
         end else if (m_pend[i] && out_ready[i]) begin
            m_pend[i] <= 1'b0;
            m_tot[i]  <= 0;
         end
      end
   end

   always @(posedge clk) begin
      #2;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("in_ready[%0d]", i), longint'(d_ir[i]), longint'(!m_pend[i]));
         check($sformatf("out_valid[%0d]", i), longint'(d_ov[i]), longint'(m_pend[i]));
         if (m_pend[i]) begin
            check($sformatf("out_sum[%0d]", i), dsum[i], exp_sum(i));
            check($sformatf("out_ovf[%0d]", i), longint'(d_of[i]),
                  longint'(m_tot[i] > max_of(i)));
         end else if (m_after_rst[i]) begin
            check($sformatf("rst_sum[%0d]", i), dsum[i], 0);
            check($sformatf("rst_ovf[%0d]", i), longint'(d_of[i]), 0);
         end
      end
   end

   // drive one instance for one cycle; inputs change 4 time units after the edge
   task automatic step(input int i, input bit v, input int d, input bit rdy);
      in_valid[i]  = v;
      in_data[i]   = 4'(d);
      out_ready[i] = rdy;
      @(posedge clk);
      #4;
   endtask

   task automatic expect_result(input string name, input int i, input longint s, input longint o);
      check({name, "_valid"}, longint'(d_ov[i]), 1);
      check({name, "_sum"}, dsum[i], s);
      check({name, "_ovf"}, longint'(d_of[i]), o);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         in_valid[i]  = 1'b0;
         in_data[i]   = '0;
         out_ready[i] = 1'b1;
      end
      reset = 1'b1;
      @(posedge clk);
      #4;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("reset_in_ready[%0d]", i), longint'(d_ir[i]), 1);
         check($sformatf("reset_out_valid[%0d]", i), longint'(d_ov[i]), 0);
      end

      // full-scale operands back-to-back
      step(0, 1, 15, 1); step(0, 1, 15, 1); step(0, 1, 15, 1);
      expect_result("full_scale", 0, 45, 0);
      step(0, 0, 0, 1);
      check("full_scale_ready_again", longint'(d_ir[0]), 1);

      // bubbles between operands
      step(0, 1, 3, 1); step(0, 0, 0, 1); step(0, 0, 0, 1);
      step(0, 1, 4, 1); step(0, 0, 0, 1);
      check("bubble_no_early_valid", longint'(d_ov[0]), 0);
      step(0, 1, 5, 1);
      expect_result("bubbles", 0, 12, 0);
      step(0, 0, 0, 1);

      // output backpressure with in_valid held high
      step(0, 1, 1, 0); step(0, 1, 2, 0); step(0, 1, 3, 0);
      expect_result("bp_first", 0, 6, 0);
      for (int k = 0; k < 5; k++) begin
         step(0, 1, 9, 0);
         check("bp_hold_sum", dsum[0], 6);
         check("bp_in_ready", longint'(d_ir[0]), 0);
      end
      step(0, 0, 0, 1);
      check("bp_consumed", longint'(d_ov[0]), 0);
      step(0, 1, 4, 1); step(0, 1, 4, 1); step(0, 1, 4, 1);
      expect_result("after_bp", 0, 12, 0);
      step(0, 0, 0, 1);

      // overflow at OW=4: 9+9+1 = 19
      step(1, 1, 9, 1); step(1, 1, 9, 1); step(1, 1, 1, 1);
`ifdef ADD_MULTI_SEQ_SAT_EN
      expect_result("ovf_sat", 1, 15, 1);
`else
      expect_result("ovf_wrap", 1, 3, 1);
`endif
      step(1, 0, 0, 1);
      step(1, 1, 1, 1); step(1, 1, 1, 1); step(1, 1, 1, 1);
      expect_result("post_ovf", 1, 3, 0);
      step(1, 0, 0, 1);

      // reset mid-operation, with an operand offered in the reset cycle
      step(0, 1, 7, 1); step(0, 1, 7, 1);
      reset = 1'b1;
      step(0, 1, 7, 1);
      reset = 1'b0;
      check("midrst_in_ready", longint'(d_ir[0]), 1);
      check("midrst_out_valid", longint'(d_ov[0]), 0);
      check("midrst_sum", dsum[0], 0);
      check("midrst_ovf", longint'(d_of[0]), 0);
      step(0, 1, 1, 1); step(0, 1, 2, 1); step(0, 1, 3, 1);
      expect_result("after_midrst", 0, 6, 0);
      step(0, 0, 0, 1);

      // single-operand instance
      step(2, 1, 10, 1);
      expect_result("n1_a", 2, 10, 0);
      step(2, 0, 0, 1);
      step(2, 1, 0, 1);
      expect_result("n1_b", 2, 0, 0);
      step(2, 0, 0, 1);
      step(2, 1, 15, 1);
      expect_result("n1_c", 2, 15, 0);
      step(2, 0, 0, 1);
      step(2, 0, 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
